// File: rtl/mod_arith_ctrl.sv
// Sequencer for an accumulator-style A register: single-cycle arithmetic ops and a
// radix-4 shift-and-add multiply over a 256-bit operand, with abort and sticky error flags.
module mod_arith_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [255:0] cmd_y,
  input  logic         cmd_abort,
  output logic         busy,
  output logic         done,
  output logic         ovf_err,
  output logic         ill_err,
  output logic [1:0]   a_op,
  output logic [1:0]   opt_adsb,
  output logic         a_en,
  output logic         a_clr,
  output logic         flg_mul,
  output logic         opt_acca,
  input  logic         flg_povf,
  input  logic         flg_novf
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_CLR, S_ADD, S_QRT, S_DONE
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_HALVE = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_LOADB = 3'b101;

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [255:0]   shreg_q, shreg_d;
  logic [6:0]     dig_cnt_q, dig_cnt_d;
  logic [1:0]     add_cnt_q, add_cnt_d;
  logic           ovf_err_q, ovf_err_d;
  logic           ill_err_q, ill_err_d;

  logic           accept;
  logic           cmd_illegal;
  logic [1:0]     digit;
  logic [1:0]     next_digit;

  assign accept      = (state_q == S_IDLE) && cmd_valid && !cmd_abort;
  assign cmd_illegal = cmd_op[2] & cmd_op[1];
  assign digit       = shreg_q[1:0];
  assign next_digit  = shreg_q[3:2];

  // NOTE: every variable gets its default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    shreg_d   = shreg_q;
    dig_cnt_d = dig_cnt_q;
    add_cnt_d = add_cnt_q;
    ovf_err_d = ovf_err_q;
    ill_err_d = ill_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = cmd_op;
          shreg_d   = cmd_y;
          dig_cnt_d = '0;
          add_cnt_d = '0;
          ovf_err_d = 1'b0;
          ill_err_d = cmd_illegal;
          if (cmd_illegal)          state_d = S_DONE;
          else if (cmd_op == OP_MUL) state_d = S_CLR;
          else                       state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_CLR:  state_d = (digit != 2'd0) ? S_ADD : S_QRT;
      S_ADD: begin
        if (flg_povf || flg_novf) ovf_err_d = 1'b1;
        // add_cnt counts completed ADD cycles of the current digit
        if (add_cnt_q == digit - 2'd1) begin
          add_cnt_d = '0;
          state_d   = S_QRT;
        end else begin
          add_cnt_d = add_cnt_q + 2'd1;
        end
      end
      S_QRT: begin
        shreg_d   = shreg_q >> 2;
        dig_cnt_d = dig_cnt_q + 7'd1;
        if (dig_cnt_q == 7'd127)      state_d = S_DONE;
        else if (next_digit != 2'd0)  state_d = S_ADD;
        else                          state_d = S_QRT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cmd_abort && (state_q inside {S_EXEC, S_CLR, S_ADD, S_QRT})) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only; the wide shift register is reset too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      shreg_q   <= '0;
      dig_cnt_q <= '0;
      add_cnt_q <= '0;
      ovf_err_q <= 1'b0;
      ill_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      shreg_q   <= shreg_d;
      dig_cnt_q <= dig_cnt_d;
      add_cnt_q <= add_cnt_d;
      ovf_err_q <= ovf_err_d;
      ill_err_q <= ill_err_d;
    end
  end

  // A-register controls depend only on registered state, never on cmd_* inputs.
  always_comb begin
    a_op     = 2'b00;
    opt_adsb = 2'b00;
    a_en     = 1'b0;
    a_clr    = 1'b0;
    flg_mul  = 1'b0;
    opt_acca = 1'b0;
    case (state_q)
      S_EXEC: begin
        a_en = 1'b1;
        case (op_q)
          OP_LOAD:  a_op = 2'b00;
          OP_ADD:   a_op = 2'b11;
          OP_SUB: begin
            a_op     = 2'b11;
            opt_adsb = 2'b01;
          end
          OP_HALVE: a_op = 2'b01;
          OP_LOADB: opt_acca = 1'b1;
          default:  a_op = 2'b00;
        endcase
      end
      S_CLR: a_clr = 1'b1;
      S_ADD: begin
        a_en = 1'b1;
        a_op = 2'b11;
      end
      S_QRT: begin
        a_en    = 1'b1;
        a_op    = 2'b10;
        flg_mul = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ovf_err   = ovf_err_q;
  assign ill_err   = ill_err_q;

endmodule

// File: doc/mod_arith_ctrl.md
MOD_ARITH_CTRL -- requirements
Module: mod_arith_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low: clk input 1 (rising-edge clock), rst_n input 1 (synchronous, active-low reset).
REQ-002 The block SHALL have these command ports:
- cmd_valid input 1 -- command request
- cmd_ready output 1 -- controller idle and able to accept
- cmd_op input 3 -- command opcode
- cmd_y input 256 -- multiplier operand, used by MUL only
- cmd_abort input 1 -- terminate the current command
REQ-003 The block SHALL have these status ports:
- busy output 1 -- command in progress
- done output 1 -- one-cycle completion pulse
- ovf_err output 1 -- sticky overflow seen during MUL
- ill_err output 1 -- sticky illegal opcode
REQ-004 The block SHALL drive the A-register controls: a_op output 2, opt_adsb output 2, a_en output 1, a_clr output 1, flg_mul output 1, opt_acca output 1.
REQ-005 The block SHALL take flg_povf input 1 and flg_novf input 1 (A-register overflow flags).

Function
REQ-006 Opcodes SHALL be:
- 000 LOAD: a_op=00, opt_acca=0 (A<=X)
- 001 ADD: a_op=11, opt_adsb=00
- 010 SUB: a_op=11, opt_adsb=01
- 011 HALVE: a_op=01
- 100 MUL
- 101 LOADB: a_op=00, opt_acca=1 (A<=B)
- 110 and 111: illegal
REQ-007 The FSM states SHALL be IDLE, EXEC, CLR, ADD, QRT and DONE; cmd_ready=1 only in IDLE.
REQ-008 A command SHALL be accepted on a cycle with cmd_valid=1, cmd_ready=1 and cmd_abort=0; on acceptance the block SHALL register cmd_op and cmd_y and clear ovf_err and ill_err.
REQ-009 In IDLE and DONE, a_en, a_clr, flg_mul and opt_acca SHALL be 0, a_op=00 and opt_adsb=00.
REQ-010 On acceptance of LOAD, ADD, SUB, HALVE or LOADB, the block SHALL go IDLE->EXEC->DONE->IDLE; EXEC lasts one cycle with a_en=1 and the encoding from REQ-006.
REQ-011 An illegal opcode SHALL go IDLE->DONE->IDLE with no a_en and no a_clr, and set ill_err.
REQ-012 On acceptance of MUL, the block SHALL go to CLR; CLR lasts one cycle with a_clr=1, and a 7-bit digit counter and the operand shift register are initialised.
REQ-013 MUL SHALL process cmd_y as 128 radix-4 digits, LSB-first; the current digit is d = shreg[1:0].
REQ-014 For each digit, ADD SHALL run for d cycles (0..3) with a_op=11, opt_adsb=00, a_en=1 and flg_mul=0, counted by a 2-bit counter; when d=0, ADD is skipped.
REQ-015 Each digit SHALL end with one QRT cycle: a_op=10, flg_mul=1, a_en=1; during QRT the shift register shifts right by 2 and the digit counter increments.
REQ-016 After the QRT for digit 127 (counter wraps 127->0), the block SHALL go to DONE; otherwise it goes to ADD, or directly to QRT when the next digit is 0.
REQ-017 MUL latency, from the acceptance edge to done=1, SHALL be 1 + sum(d_i) + 128 + 1 cycles.
REQ-018 ovf_err SHALL be set when flg_povf or flg_novf is 1 in any ADD cycle of MUL; it holds until the next acceptance or reset, and MUL continues to completion.
REQ-019 busy SHALL be 1 in EXEC, CLR, ADD, QRT and DONE.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle per command.
REQ-021 cmd_abort=1 in EXEC, CLR, ADD or QRT SHALL force a transition to IDLE on the next edge with a_en=0 in that cycle; no done pulse is produced and the sticky flags are retained.
REQ-022 cmd_abort in IDLE or DONE SHALL be ignored; if cmd_abort and cmd_valid are both 1 in IDLE, the command is not accepted.
REQ-023 cmd_valid asserted while busy SHALL be ignored: no queueing, and cmd_op/cmd_y changes have no effect.
REQ-024 All outputs to the A register SHALL be decoded from the registered state only, so there is no combinational path from cmd_* to a_*.

Reset
REQ-025 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear busy, done, ovf_err, ill_err, both counters and the shift register; all a_* controls are 0 and cmd_ready=1 from the first cycle after reset.
REQ-026 rst_n=0 mid-command SHALL abandon the command with no done pulse.

Verification
REQ-027 The bench SHALL cover LOAD then ADD, each with cmd_valid for 1 cycle: each gives exactly one EXEC cycle (a_en=1; a_op=00 for LOAD, a_op=11/opt_adsb=00 for ADD) and done 2 cycles after acceptance.
REQ-028 The bench SHALL cover MUL with cmd_y=0: one a_clr cycle, 128 QRT cycles, no ADD cycles, and done 130 cycles after acceptance.
REQ-029 The bench SHALL cover MUL with cmd_y=all ones: 384 ADD cycles interleaved as 3 ADD then 1 QRT, and done 514 cycles after acceptance.
REQ-030 The bench SHALL cover MUL with cmd_y=0x...0006 (digits 2,1, rest 0) and flg_povf=1 during the first ADD: the sequence is CLR, ADD, ADD, QRT, ADD, QRT, then 126 QRT; ovf_err=1 at done and clears on the next acceptance.
REQ-031 The bench SHALL cover cmd_abort asserted in QRT of digit 10: a_en=0 on the next cycle, IDLE, no done, and cmd_ready=1.
REQ-032 The bench SHALL cover cmd_op=110: no a_en and no a_clr, done 1 cycle after acceptance, ill_err=1; and rst_n=0 during MUL: all outputs return to reset values on the next edge.
